led_pattern_gen: RTL and testbench

Parametrised LED pattern generator driven from CLOCK_50. It produces one of four patterns on an N-bit LED bank: off, blink, chase or bounce. The pattern advances on a rate-selectable tick, or on a single-step pulse while paused. It sits between the board switch/key inputs and the LEDG/LEDR outputs at the top level. It generalises the fixed three-rate single-LED blinker by adding width, four parameterised rates, pattern modes, pause/step, and clean restart on mode or rate change.

---
 rtl/led_pattern_gen_if.sv | 25 ++
 rtl/led_pattern_gen.sv | 144 ++++++++++++++
 tb/tb_led_pattern_gen.sv | 162 ++++++++++++++++
 3 files changed

// File: rtl/led_pattern_gen_if.sv
// Board-side bundle for the LED pattern generator: switch/key controls in, LED bank out.
// Latency: none (signal bundle only).
// Backpressure: none; controls are levels sampled every cycle, outputs are free-running.
interface led_pattern_gen_if #(
    parameter int N_LEDS = 8
);
    logic [1:0]        MODE;
    logic [1:0]        RATE;
    logic              RUN;
    logic              STEP;
    logic [N_LEDS-1:0] LEDS;
    logic              TICK;

    // Board side: drives the controls, watches the LEDs.
    modport master (
        output MODE, RATE, RUN, STEP,
        input  LEDS, TICK
    );

    // Generator side.
    modport slave (
        input  MODE, RATE, RUN, STEP,
        output LEDS, TICK
    );
endinterface

// File: rtl/led_pattern_gen.sv
// LED pattern generator: off / blink / chase / bounce, advanced by a rate tick or single step.
// Latency: restart or advance visible on LEDS/TICK one edge after the deciding inputs are sampled.
// Backpressure: none; STEP is edge-detected, RUN=0 freezes the tick counter.
module led_pattern_gen #(
    parameter int N_LEDS = 8,
    parameter int CNT_W  = 28,
    parameter int TICK0  = 50000000,
    parameter int TICK1  = 25000000,
    parameter int TICK2  = 12500000,
    parameter int TICK3  = 90000000
) (
    input  logic             CLOCK_50,
    input  logic             RESET_N,
    led_pattern_gen_if.slave bus
);
    localparam int POS_W = (N_LEDS > 1) ? $clog2(N_LEDS) : 1;
    localparam logic [POS_W-1:0] LAST = POS_W'(N_LEDS - 1);

    logic [CNT_W-1:0]  cnt, cnt_d;
    logic [1:0]        mode_q, mode_d;
    logic [1:0]        rate_q, rate_d;
    logic [POS_W-1:0]  pos, pos_d;
    logic              dir, dir_d;
    logic              blk, blk_d;
    logic              step_q;
    logic [N_LEDS-1:0] leds_q, leds_d;
    logic              tick_q, tick_d;
    logic              restart;
    logic              adv;
    logic [CNT_W-1:0]  lim;

    // Terminal count for the latched rate; raw RATE never reaches the compare.
    always_comb begin
        case (rate_q)
            2'd0:    lim = CNT_W'(TICK0 - 1);
            2'd1:    lim = CNT_W'(TICK1 - 1);
            2'd2:    lim = CNT_W'(TICK2 - 1);
            default: lim = CNT_W'(TICK3 - 1);
        endcase
    end

    assign restart = (bus.MODE != mode_q) || (bus.RATE != rate_q);

    // Next-state: restart wins over any due advance; otherwise count or step, then advance the pattern.
    always_comb begin
        cnt_d  = cnt;
        mode_d = mode_q;
        rate_d = rate_q;
        pos_d  = pos;
        dir_d  = dir;
        blk_d  = blk;
        leds_d = leds_q;
        tick_d = 1'b0;
        adv    = 1'b0;

        if (restart) begin
            mode_d = bus.MODE;
            rate_d = bus.RATE;
            cnt_d  = '0;
            pos_d  = '0;
            dir_d  = 1'b0;
            blk_d  = 1'b1;
            case (bus.MODE)
                2'd0:    leds_d = '0;
                2'd1:    leds_d = '1;
                default: leds_d = N_LEDS'(1);
            endcase
        end else begin
            if (bus.RUN) begin
                // STEP is ignored while free-running.
                if (cnt == lim) begin
                    cnt_d = '0;
                    adv   = 1'b1;
                end else begin
                    cnt_d = cnt + CNT_W'(1);
                end
            end else if (bus.STEP && !step_q) begin
                adv = 1'b1;
            end

            if (adv) begin
                tick_d = 1'b1;
                case (mode_q)
                    2'd0: leds_d = '0;
                    2'd1: begin
                        blk_d  = ~blk;
                        leds_d = blk ? '0 : '1;
                    end
                    2'd2: begin
                        pos_d  = (pos == LAST) ? '0 : pos + POS_W'(1);
                        leds_d = N_LEDS'(1) << pos_d;
                    end
                    default: begin
                        // Endpoints reverse direction and move one step inward so each is shown once.
                        if (!dir) begin
                            if (pos == LAST) begin
                                dir_d = 1'b1;
                                pos_d = LAST - POS_W'(1);
                            end else begin
                                pos_d = pos + POS_W'(1);
                            end
                        end else begin
                            if (pos == '0) begin
                                dir_d = 1'b0;
                                pos_d = POS_W'(1);
                            end else begin
                                pos_d = pos - POS_W'(1);
                            end
                        end
                        leds_d = N_LEDS'(1) << pos_d;
                    end
                endcase
            end
        end
    end

    // State and output registers.
    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            cnt    <= '0;
            mode_q <= 2'd0;
            rate_q <= 2'd0;
            pos    <= '0;
            dir    <= 1'b0;
            blk    <= 1'b0;
            step_q <= 1'b0;
            leds_q <= '0;
            tick_q <= 1'b0;
        end else begin
            cnt    <= cnt_d;
            mode_q <= mode_d;
            rate_q <= rate_d;
            pos    <= pos_d;
            dir    <= dir_d;
            blk    <= blk_d;
            step_q <= bus.STEP;
            leds_q <= leds_d;
            tick_q <= tick_d;
        end
    end

    assign bus.LEDS = leds_q;
    assign bus.TICK = tick_q;
endmodule

// File: tb/tb_led_pattern_gen.sv
// Bench for led_pattern_gen with N_LEDS=4 and periods 4/2/3/5.
// Each vector is one clock: drive inputs, take an edge, compare LEDS/TICK 1 ns later.
// Async reset is exercised by hand between edges at the end.
module tb_led_pattern_gen;
    localparam int N = 4;

    typedef struct {
        logic [1:0]   mode;
        logic [1:0]   rate;
        logic         run;
        logic         step;
        logic [N-1:0] leds;
        logic         tick;
    } vec_t;

    logic clk;
    logic rst_n;
    int   total;
    int   bad;
    vec_t vecs[$];

    led_pattern_gen_if #(.N_LEDS(N)) bus ();

    led_pattern_gen #(
        .N_LEDS(N),
        .CNT_W (8),
        .TICK0 (4),
        .TICK1 (2),
        .TICK2 (3),
        .TICK3 (5)
    ) dut (
        .CLOCK_50(clk),
        .RESET_N (rst_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic add(input logic [1:0] m, input logic [1:0] r, input logic ru,
                       input logic st, input logic [N-1:0] l, input logic t);
        vec_t v;
        v.mode = m; v.rate = r; v.run = ru; v.step = st; v.leds = l; v.tick = t;
        vecs.push_back(v);
    endtask

    task automatic check(input string name, input logic [N-1:0] l, input logic t);
        total++;
        if (bus.LEDS !== l || bus.TICK !== t) begin
            bad++;
            $display("FAIL %s: got LEDS=%b TICK=%b, want LEDS=%b TICK=%b",
                     name, bus.LEDS, bus.TICK, l, t);
        end
    endtask

    task automatic cycle(input vec_t v, input string name);
        bus.MODE = v.mode;
        bus.RATE = v.rate;
        bus.RUN  = v.run;
        bus.STEP = v.step;
        @(posedge clk);
        #1;
        check(name, v.leds, v.tick);
    endtask

    initial begin
        vec_t v;
        logic [N-1:0] seq[7];
        total = 0;
        bad   = 0;

        // OFF after reset: counter runs at rate 0, TICK pulses with LEDS dark.
        for (int i = 0; i < 3; i++) add(0, 0, 1, 0, 4'b0000, 0);
        add(0, 0, 1, 0, 4'b0000, 1);

        // Chase at T=4.
        add(2, 0, 1, 0, 4'b0001, 0);
        for (int k = 0; k < 4; k++) begin
            logic [N-1:0] nxt;
            nxt = 4'b0001 << ((k + 1) % 4);
            for (int i = 0; i < 3; i++) add(2, 0, 1, 0, 4'b0001 << k, 0);
            add(2, 0, 1, 0, nxt, 1);
        end

        // Bounce at T=2.
        seq = '{4'b0010, 4'b0100, 4'b1000, 4'b0100, 4'b0010, 4'b0001, 4'b0010};
        add(3, 1, 1, 0, 4'b0001, 0);
        add(3, 1, 1, 0, 4'b0001, 0);
        for (int k = 0; k < 7; k++) begin
            add(3, 1, 1, 0, seq[k], 1);
            if (k < 6) add(3, 1, 1, 0, seq[k], 0);
        end

        // Blink at T=3, then rate change mid-count restarts with T=5.
        add(1, 2, 1, 0, 4'b1111, 0);
        add(1, 2, 1, 0, 4'b1111, 0);
        add(1, 2, 1, 0, 4'b1111, 0);
        add(1, 2, 1, 0, 4'b0000, 1);
        add(1, 2, 1, 0, 4'b0000, 0);
        add(1, 2, 1, 0, 4'b0000, 0);
        add(1, 2, 1, 0, 4'b1111, 1);
        add(1, 2, 1, 0, 4'b1111, 0);
        add(1, 3, 1, 0, 4'b1111, 0);
        for (int i = 0; i < 4; i++) add(1, 3, 1, 0, 4'b1111, 0);
        add(1, 3, 1, 0, 4'b0000, 1);

        // Paused chase: STEP high 6, low 2, high 1 gives exactly two advances.
        add(2, 3, 0, 0, 4'b0001, 0);
        add(2, 3, 0, 1, 4'b0010, 1);
        for (int i = 0; i < 5; i++) add(2, 3, 0, 1, 4'b0010, 0);
        add(2, 3, 0, 0, 4'b0010, 0);
        add(2, 3, 0, 0, 4'b0010, 0);
        add(2, 3, 0, 1, 4'b0100, 1);
        add(2, 3, 0, 0, 4'b0100, 0);
        // Resume: STEP rise ignored while running; counter resumes from 0, advance after 5 edges.
        add(2, 3, 1, 1, 4'b0100, 0);
        for (int i = 0; i < 3; i++) add(2, 3, 1, 0, 4'b0100, 0);
        add(2, 3, 1, 0, 4'b1000, 1);

        // STEP rise coincident with MODE 2->3: restart only, held STEP gives no later advance.
        add(3, 3, 0, 1, 4'b0001, 0);
        add(3, 3, 0, 1, 4'b0001, 0);
        add(3, 3, 0, 0, 4'b0001, 0);

        bus.MODE = 0; bus.RATE = 0; bus.RUN = 0; bus.STEP = 0;
        rst_n = 1'b0;
        #12;
        total++;
        if (bus.LEDS !== 4'b0000 || bus.TICK !== 1'b0) begin
            bad++;
            $display("FAIL reset: got LEDS=%b TICK=%b, want 0000 0", bus.LEDS, bus.TICK);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        for (int i = 0; i < vecs.size(); i++) cycle(vecs[i], $sformatf("vec[%0d]", i));

        // Mid-chase async reset, taken between edges.
        add(2, 1, 1, 0, 4'b0001, 0);
        cycle(vecs[$], "rst_pre0");
        add(2, 1, 1, 0, 4'b0001, 0);
        cycle(vecs[$], "rst_pre1");
        add(2, 1, 1, 0, 4'b0010, 1);
        cycle(vecs[$], "rst_pre2");
        #2;
        rst_n = 1'b0;
        #1;
        check("rst_async", 4'b0000, 1'b0);
        @(posedge clk);
        #1;
        check("rst_held", 4'b0000, 1'b0);
        rst_n = 1'b1;
        v.mode = 2; v.rate = 0; v.run = 1; v.step = 0; v.leds = 4'b0001; v.tick = 0;
        cycle(v, "rst_restart");
        v.leds = 4'b0001; v.tick = 0;
        cycle(v, "rst_after");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
